// File: rtl/serialtoparallel_rx.sv
// Serial-to-parallel receiver: shifts in a framesize+1 bit MSB-first frame while
// receive is high and presents the last WIDTH bits as a registered word.
module serialtoparallel_rx #(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [WIDTH-1:0] framesize,
   input  logic             receive,
   input  logic             serial,
   output logic [WIDTH-1:0] parallel,
   output logic             valid,
   output logic             busy,
   output logic             abort,
   output logic [WIDTH-1:0] frame_count
);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LOW} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] fs_q, fs_d;
   logic [WIDTH-1:0] bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] parallel_q, parallel_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             abort_q, abort_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] first_word;

   assign shifted    = {shreg_q[WIDTH-2:0], serial};
   assign first_word = {{(WIDTH-1){1'b0}}, serial};

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= IDLE;
         fs_q       <= '0;
         bitcnt_q   <= '0;
         shreg_q    <= '0;
         parallel_q <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fs_q       <= fs_d;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         parallel_q <= parallel_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         abort_q    <= abort_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fs_d       = fs_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      parallel_d = parallel_q;
      count_d    = count_q;
      valid_d    = 1'b0;
      abort_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (Enable && receive) begin
               fs_d     = framesize;
               shreg_d  = first_word;
               bitcnt_d = WIDTH'(1);
               // A one-bit frame completes on the very edge that starts it.
               if (framesize == '0) begin
                  parallel_d = first_word;
                  valid_d    = 1'b1;
                  count_d    = count_q + WIDTH'(1);
                  state_d    = WAIT_LOW;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            // A dropped receive truncates the frame even when Enable is low.
            if (!receive) begin
               abort_d = 1'b1;
               state_d = IDLE;
            end else if (Enable) begin
               shreg_d  = shifted;
               bitcnt_d = bitcnt_q + WIDTH'(1);
               if (bitcnt_q == fs_q) begin
                  parallel_d = shifted;
                  valid_d    = 1'b1;
                  count_d    = count_q + WIDTH'(1);
                  state_d    = WAIT_LOW;
               end
            end
         end
         WAIT_LOW: begin
            if (!receive) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign parallel    = parallel_q;
   assign valid       = valid_q;
   assign abort       = abort_q;
   assign busy        = (state_q == SHIFT);
   assign frame_count = count_q;

endmodule

// File: tb/tb_serialtoparallel_rx.sv
// Directed bench for serialtoparallel_rx: frame-level reference model checked every
// cycle, plus literal expectations at the scenario end points.
module tb_serialtoparallel_rx;

   localparam int W = 8;

   logic         Clock = 1'b0;
   logic         Reset;
   logic         Enable;
   logic [W-1:0] framesize;
   logic         receive;
   logic         serial;
   logic [W-1:0] parallel;
   logic         valid;
   logic         busy;
   logic         abort;
   logic [W-1:0] frame_count;

   serialtoparallel_rx #(.WIDTH(W)) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .framesize(framesize),
      .receive(receive), .serial(serial), .parallel(parallel), .valid(valid),
      .busy(busy), .abort(abort), .frame_count(frame_count)
   );

   always #5 Clock = ~Clock;

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Frame-level model: collects sampled bits, word = last W bits of the frame.
   bit           in_frame, need_low;
   int           target;
   bit           bits_q[$];
   logic [W-1:0] m_par, m_cnt;
   bit           m_valid, m_abort;
   logic [W-1:0] exp_q[$];

   function automatic logic [W-1:0] last_bits();
      logic [W-1:0] v = '0;
      int lo = (bits_q.size() > W) ? bits_q.size() - W : 0;
      for (int i = lo; i < bits_q.size(); i++) v = {v[W-2:0], bits_q[i]};
      return v;
   endfunction

   function automatic void complete_frame();
      m_par   = last_bits();
      m_valid = 1'b1;
      m_cnt   = m_cnt + 8'd1;
      exp_q.push_back(m_par);
      in_frame = 0;
      need_low = 1;
   endfunction

   always @(posedge Clock) begin
      m_valid = 1'b0;
      m_abort = 1'b0;
      if (Reset) begin
         in_frame = 0; need_low = 0; bits_q.delete();
         m_par = '0; m_cnt = '0;
      end else if (in_frame) begin
         if (!receive) begin
            m_abort = 1'b1;
            in_frame = 0;
         end else if (Enable) begin
            bits_q.push_back(serial);
            if (bits_q.size() == target) complete_frame();
         end
      end else if (need_low) begin
         if (!receive) need_low = 0;
      end else if (Enable && receive) begin
         target = int'(framesize) + 1;
         bits_q.delete();
         bits_q.push_back(serial);
         in_frame = 1;
         if (target == 1) complete_frame();
      end
   end

   always @(negedge Clock) begin
      if (cmp_en) begin
         check("valid", valid, m_valid);
         check("abort", abort, m_abort);
         check("busy", busy, in_frame);
         check("frame_count", frame_count, m_cnt);
         check("parallel", parallel, m_par);
         if (valid) begin
            if (exp_q.size() == 0) check("unexpected_word", 1, 0);
            else check("scoreboard_word", parallel, exp_q.pop_front());
         end
      end
   end

   task automatic tick_in(input logic rcv, input logic ser, input logic en);
      @(negedge Clock);
      receive = rcv;
      serial  = ser;
      Enable  = en;
   endtask

   task automatic send_bits(input logic [15:0] data, input int n);
      for (int i = n - 1; i >= 0; i--) tick_in(1'b1, data[i], 1'b1);
   endtask

   task automatic end_frame();
      tick_in(1'b0, 1'bz, 1'b1);
      tick_in(1'b0, 1'bz, 1'b1);
   endtask

   initial begin
      logic [7:0] tail;
      Reset = 1'b1; Enable = 1'b0; framesize = '0; receive = 1'b0; serial = 1'b0;
      @(negedge Clock);
      cmp_en = 1;
      @(negedge Clock);
      check("rst_parallel", parallel, 8'h00);
      check("rst_count", frame_count, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", valid, 1'b0);
      Reset = 1'b0;

      // Basic 8-bit frame; receive stays high afterwards.
      framesize = 8'd7;
      send_bits(16'h00B2, 8);
      tick_in(1'b1, 1'b1, 1'b1);
      check("s1_valid", valid, 1'b1);
      check("s1_parallel", parallel, 8'hB2);
      check("s1_count", frame_count, 8'd1);
      check("s1_busy", busy, 1'b0);
      repeat (3) tick_in(1'b1, 1'b1, 1'b1);
      check("s1_hold_valid", valid, 1'b0);
      check("s1_hold_busy", busy, 1'b0);
      end_frame();

      // Short frames are right-aligned.
      framesize = 8'd0;
      send_bits(16'h0001, 1);
      tick_in(1'b0, 1'b0, 1'b1);
      check("s2_one_bit", parallel, 8'h01);
      check("s2_one_valid", valid, 1'b1);
      tick_in(1'b0, 1'b0, 1'b1);
      framesize = 8'd3;
      send_bits(16'h000D, 4);
      tick_in(1'b0, 1'b0, 1'b1);
      check("s2_four_bit", parallel, 8'h0D);
      tick_in(1'b0, 1'b0, 1'b1);

      // Truncated frame after a good one.
      framesize = 8'd7;
      send_bits(16'h00B2, 8);
      end_frame();
      send_bits(16'h000B, 4);
      tick_in(1'b0, 1'b0, 1'b1);
      tick_in(1'b0, 1'b0, 1'b1);
      check("s3_abort", abort, 1'b1);
      check("s3_valid", valid, 1'b0);
      check("s3_parallel", parallel, 8'hB2);
      check("s3_count", frame_count, 8'd4);
      tick_in(1'b0, 1'b0, 1'b1);
      check("s3_abort_width", abort, 1'b0);

      // Enable gap mid-frame, with framesize changed during the frame.
      framesize = 8'd7;
      send_bits(16'h000B, 4);
      framesize = 8'd2;
      tick_in(1'b1, 1'b0, 1'b0);
      tick_in(1'b1, 1'b1, 1'b0);
      tick_in(1'b1, 1'b0, 1'b0);
      send_bits(16'h0002, 4);
      tick_in(1'b1, 1'b0, 1'b1);
      check("s4_parallel", parallel, 8'hB2);
      check("s4_count", frame_count, 8'd5);
      end_frame();

      // Long frames keep the last W bits.
      framesize = 8'd9;
      send_bits(16'h03A5, 10);
      tick_in(1'b0, 1'b0, 1'b1);
      check("s5_parallel", parallel, 8'hA5);
      tick_in(1'b0, 1'b0, 1'b1);

      // Maximum-length frame: 256 bits.
      framesize = 8'd255;
      tail = 8'h5A;
      for (int i = 0; i < 256; i++)
         tick_in(1'b1, (i >= 248) ? tail[255 - i] : i[0], 1'b1);
      tick_in(1'b0, 1'b0, 1'b1);
      check("max_parallel", parallel, 8'h5A);
      check("max_count", frame_count, 8'd7);
      tick_in(1'b0, 1'b0, 1'b1);

      // 249 more one-bit frames bring the total to 256.
      framesize = 8'd0;
      for (int i = 0; i < 249; i++) begin
         tick_in(1'b1, 1'($urandom_range(0, 1)), 1'b1);
         tick_in(1'b0, 1'b0, 1'b1);
      end
      tick_in(1'b0, 1'b0, 1'b1);
      check("wrap_count", frame_count, 8'd0);

      // Reset in the middle of a frame.
      framesize = 8'd7;
      send_bits(16'h0015, 5);
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0; receive = 1'b0;
      check("rst_mid_parallel", parallel, 8'h00);
      check("rst_mid_count", frame_count, 8'h00);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_valid", valid, 1'b0);
      check("rst_mid_abort", abort, 1'b0);
      send_bits(16'h003C, 8);
      tick_in(1'b0, 1'b0, 1'b1);
      check("s6_parallel", parallel, 8'h3C);
      check("s6_count", frame_count, 8'd1);
      end_frame();

      check("scoreboard_drained", exp_q.size(), 0);
      cmp_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
